// File: rtl/mem_bus_pkg.sv
// Shared encodings and default widths for the backing-memory arbiter.
package mem_bus_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way picker for the fetch (i) and data (d) requesters.
// Round-robin by default; PRIO_D=1 makes d win every tie.
module rr_arb2 import mem_bus_pkg::*; #(
    parameter int PRIO_D = 0
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_i,
    output logic grant_d
);

    // d wins when alone, when fixed-priority, or when i had the last turn
    always_comb begin
        grant_d = req_d && (!req_i || (PRIO_D != 0) || (last_grant == OWN_I));
        grant_i = req_i && !grant_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the icache refill port and the dcache port.
// One transaction in flight; a response timeout returns an error to the owner
// and drains the late downstream response before the next grant.
module mem_arbiter import mem_bus_pkg::*; #(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int PRIO_D  = 0,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_avalid,
    output logic              i_aready,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW/8-1:0]   i_wstrb,
    output logic [DW-1:0]     i_rdata,
    output logic              i_bvalid,
    input  logic              i_bready,
    output logic              i_err,
    input  logic [AW-1:0]     d_addr,
    input  logic              d_avalid,
    output logic              d_aready,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_wstrb,
    output logic [DW-1:0]     d_rdata,
    output logic              d_bvalid,
    input  logic              d_bready,
    output logic              d_err,
    output logic [AW-1:0]     m_addr,
    output logic              m_avalid,
    input  logic              m_aready,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wstrb,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              busy
);

    localparam int SW = DW / 8;
    // One spare bit: the timer may step one past TIMEOUT-1 when the request
    // handshake lands exactly on the last allowed cycle.
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;
    logic            last_grant_reg, last_grant_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            drain_reg, drain_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [SW-1:0]   wstrb_reg, wstrb_next;
    logic            grant_i, grant_d;
    logic            own_bready;
    logic            timed_out;

    rr_arb2 #(.PRIO_D(PRIO_D)) u_pick (
        .req_i      (i_avalid),
        .req_d      (d_avalid),
        .last_grant (last_grant_reg),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    assign own_bready = (owner_reg == OWN_D) ? d_bready : i_bready;
    assign timed_out  = (timer_reg >= TW'(TIMEOUT - 1));
    assign m_addr     = addr_reg;
    assign m_wdata    = wdata_reg;
    assign m_wstrb    = wstrb_reg;
    assign busy       = (state_reg != IDLE) || drain_reg;

    // State, ownership, timer and latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_I;
            last_grant_reg <= OWN_D;
            timer_reg      <= '0;
            drain_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            timer_reg      <= timer_next;
            drain_reg      <= drain_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
        end
    end

    // Next-state logic plus requester/downstream handshake outputs
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        timer_next      = timer_reg;
        drain_next      = drain_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        i_aready        = 1'b0;
        d_aready        = 1'b0;
        i_bvalid        = 1'b0;
        d_bvalid        = 1'b0;
        i_err           = 1'b0;
        d_err           = 1'b0;
        i_rdata         = '0;
        d_rdata         = '0;
        m_avalid        = 1'b0;
        m_bready        = drain_reg;

        // A response orphaned by a timeout is swallowed here
        if (drain_reg && m_bvalid) begin
            drain_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!drain_reg && (grant_i || grant_d)) begin
                    // aready is combinational, so mask it while reset is held
                    i_aready        = grant_i & rst;
                    d_aready        = grant_d & rst;
                    owner_next      = grant_d ? OWN_D : OWN_I;
                    last_grant_next = grant_d ? OWN_D : OWN_I;
                    addr_next       = grant_d ? d_addr  : i_addr;
                    wdata_next      = grant_d ? d_wdata : i_wdata;
                    wstrb_next      = grant_d ? d_wstrb : i_wstrb;
                    timer_next      = '0;
                    state_next      = REQ;
                end
            end
            REQ: begin
                m_avalid   = 1'b1;
                timer_next = timer_reg + TW'(1);
                if (m_aready) begin
                    state_next = RESP;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            RESP: begin
                m_bready   = own_bready;
                timer_next = timer_reg + TW'(1);
                if (owner_reg == OWN_D) begin
                    d_bvalid = m_bvalid;
                    d_rdata  = m_bvalid ? m_rdata : '0;
                end else begin
                    i_bvalid = m_bvalid;
                    i_rdata  = m_bvalid ? m_rdata : '0;
                end
                if (m_bvalid && own_bready) begin
                    state_next = IDLE;
                end else if (timed_out) begin
                    state_next = ERR;
                    drain_next = 1'b1;
                end
            end
            ERR: begin
                if (owner_reg == OWN_D) begin
                    d_bvalid = 1'b1;
                    d_err    = 1'b1;
                end else begin
                    i_bvalid = 1'b1;
                    i_err    = 1'b1;
                end
                if (own_bready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, timeout/drain and reset
// sequences, a fixed-priority instance, and randomized traffic checked
// against a transaction-level model of the grant rules.
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk, rst;
    logic [31:0] i_addr, d_addr, m_addr;
    logic        i_avalid, d_avalid, i_aready, d_aready;
    logic [63:0] i_wdata, d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
    logic [7:0]  i_wstrb, d_wstrb, m_wstrb;
    logic        i_bvalid, d_bvalid, i_bready, d_bready, i_err, d_err;
    logic        m_avalid, m_aready, m_bvalid, m_bready, busy;

    logic        f_i_avalid, f_d_avalid, f_i_aready, f_d_aready;
    logic [63:0] f_i_rdata, f_d_rdata, f_m_wdata;
    logic        f_i_bvalid, f_d_bvalid, f_i_err, f_d_err;
    logic [31:0] f_m_addr;
    logic [7:0]  f_m_wstrb;
    logic        f_m_avalid, f_m_bready, f_busy;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    bit model_last_d;

    typedef struct {
        bit          wi;
        bit          wd;
        logic [31:0] ia;
        logic [31:0] da;
        logic [63:0] wdat;
        logic [7:0]  ws;
        logic [63:0] rd;
        int          aw;
        int          rw;
        int          bw;
        bit          exp_d;
    } vec_t;

    vec_t vecs[8];

    mem_arbiter #(.AW(32), .DW(64), .PRIO_D(0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_avalid(i_avalid), .i_aready(i_aready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_rdata(i_rdata),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_err(i_err),
        .d_addr(d_addr), .d_avalid(d_avalid), .d_aready(d_aready),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata),
        .d_bvalid(d_bvalid), .d_bready(d_bready), .d_err(d_err),
        .m_addr(m_addr), .m_avalid(m_avalid), .m_aready(m_aready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy)
    );

    // Fixed-priority instance with an always-ready, always-responding memory
    mem_arbiter #(.AW(32), .DW(64), .PRIO_D(1), .TIMEOUT(TO)) dut_fix (
        .clk(clk), .rst(rst),
        .i_addr(32'h1000), .i_avalid(f_i_avalid), .i_aready(f_i_aready),
        .i_wdata(64'h0), .i_wstrb(8'h00), .i_rdata(f_i_rdata),
        .i_bvalid(f_i_bvalid), .i_bready(1'b1), .i_err(f_i_err),
        .d_addr(32'h2000), .d_avalid(f_d_avalid), .d_aready(f_d_aready),
        .d_wdata(64'h0), .d_wstrb(8'h00), .d_rdata(f_d_rdata),
        .d_bvalid(f_d_bvalid), .d_bready(1'b1), .d_err(f_d_err),
        .m_addr(f_m_addr), .m_avalid(f_m_avalid), .m_aready(1'b1),
        .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_rdata(64'h0),
        .m_bvalid(1'b1), .m_bready(f_m_bready), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tie goes to whoever was not granted last; a lone requester always wins
    function automatic bit model_pick(input bit wi, input bit wd);
        if (wi && !wd) return 1'b0;
        if (wd && !wi) return 1'b1;
        return !model_last_d;
    endfunction

    // One complete transaction starting in an IDLE cycle (at posedge+1).
    // aw: cycles m_aready stays low; rw: cycles before m_bvalid;
    // bw: cycles the owner holds bready low after m_bvalid.
    task automatic run_one(input bit wi, input bit wd, input logic [31:0] ia,
                           input logic [31:0] da, input logic [63:0] wdat,
                           input logic [7:0] ws, input logic [63:0] rd,
                           input int aw, input int rw, input int bw, input bit gd);
        i_addr = ia; i_wdata = '0; i_wstrb = '0;
        d_addr = da; d_wdata = wdat; d_wstrb = ws;
        i_avalid = wi; d_avalid = wd;
        i_bready = gd; d_bready = !gd;
        m_rdata = rd; m_aready = 1'b0; m_bvalid = 1'b0;
        #1;
        chk("busy_idle", busy, 0);
        chk("grant_i", i_aready, !gd);
        chk("grant_d", d_aready, gd);
        chk("m_avalid_idle", m_avalid, 0);
        step();
        if (gd) d_avalid = 1'b0; else i_avalid = 1'b0;
        for (int k = 0; k <= aw; k++) begin
            m_aready = (k == aw);
            #1;
            chk("m_avalid_req", m_avalid, 1);
            chk("m_addr", m_addr, gd ? da : ia);
            chk("m_wdata", m_wdata, gd ? wdat : 64'h0);
            chk("m_wstrb", m_wstrb, gd ? ws : 8'h00);
            chk("no_aready_req", {i_aready, d_aready}, 0);
            chk("m_bready_req", m_bready, 0);
            chk("busy_req", busy, 1);
            step();
        end
        m_aready = 1'b0;
        for (int k = 0; k < rw; k++) begin
            #1;
            chk("bvalid_wait", {i_bvalid, d_bvalid}, 0);
            chk("rdata_wait", i_rdata | d_rdata, 0);
            chk("m_avalid_resp", m_avalid, 0);
            step();
        end
        m_bvalid = 1'b1;
        for (int k = 0; k <= bw; k++) begin
            if (gd) d_bready = (k == bw); else i_bready = (k == bw);
            #1;
            chk("own_bvalid", gd ? d_bvalid : i_bvalid, 1);
            chk("own_rdata", gd ? d_rdata : i_rdata, rd);
            chk("own_err", {i_err, d_err}, 0);
            chk("other_bvalid", gd ? i_bvalid : d_bvalid, 0);
            chk("other_rdata", gd ? i_rdata : d_rdata, 0);
            chk("m_bready_resp", m_bready, (k == bw));
            chk("no_aready_resp", {i_aready, d_aready}, 0);
            step();
        end
        m_bvalid = 1'b0; i_bready = 1'b0; d_bready = 1'b0;
        i_avalid = 1'b0; d_avalid = 1'b0;
        model_last_d = gd;
        $display("txn %0d: owner=%s addr=%h wstrb=%h rdata=%h", txn_no, gd ? "D" : "I",
                 gd ? da : ia, gd ? ws : 8'h00, rd);
        txn_no++;
    endtask

    initial begin
        int n;
        int ci, cd;
        bit wi, wd;

        vecs[0] = '{1, 1, 32'h80000100, 32'h80000200, 64'h1, 8'h00, 64'hA0, 0, 1, 0, 0};
        vecs[1] = '{1, 1, 32'h80000104, 32'h80000208, 64'h2, 8'hFF, 64'hA1, 1, 0, 1, 1};
        vecs[2] = '{1, 1, 32'h80000108, 32'h80000210, 64'h3, 8'h00, 64'hA2, 2, 2, 0, 0};
        vecs[3] = '{1, 1, 32'h8000010C, 32'h80000218, 64'h4, 8'hF0, 64'hA3, 0, 0, 2, 1};
        vecs[4] = '{1, 0, 32'h80000000, 32'h0, 64'h0, 8'h00, 64'h00000013_00000093, 0, 3, 0, 0};
        vecs[5] = '{1, 1, 32'h80000300, 32'h80000400, 64'h0, 8'h00, 64'h55, 5, 0, 3, 1};
        vecs[6] = '{0, 1, 32'h0, 32'h80001000, 64'hDEADBEEF_CAFEF00D, 8'h0F, 64'h0, 0, 1, 0, 1};
        vecs[7] = '{1, 1, 32'h80000500, 32'h80000600, 64'h77, 8'hFF, 64'hBB, 0, 0, 0, 0};

        rst = 1'b0;
        i_addr = 32'h1; d_addr = 32'h2; i_avalid = 1'b1; d_avalid = 1'b1;
        i_wdata = '0; d_wdata = '0; i_wstrb = '0; d_wstrb = '0;
        i_bready = 1'b0; d_bready = 1'b0;
        m_aready = 1'b0; m_rdata = 64'h5A5A; m_bvalid = 1'b1;
        f_i_avalid = 1'b0; f_d_avalid = 1'b0;
        model_last_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aready", {i_aready, d_aready}, 0);
        chk("rst_bvalid", {i_bvalid, d_bvalid, i_err, d_err}, 0);
        chk("rst_m_ctrl", {m_avalid, m_bready, busy}, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        i_avalid = 1'b0; d_avalid = 1'b0; m_bvalid = 1'b0;
        rst = 1'b1;

        // Vector table: alternation, single fetch, backpressure, data write
        for (int v = 0; v < 8; v++) begin
            run_one(vecs[v].wi, vecs[v].wd, vecs[v].ia, vecs[v].da, vecs[v].wdat,
                    vecs[v].ws, vecs[v].rd, vecs[v].aw, vecs[v].rw, vecs[v].bw,
                    vecs[v].exp_d);
        end

        // Timeout in RESP, error to the fetch side, then drain before d is served
        i_addr = 32'h80002000; i_avalid = 1'b1; d_avalid = 1'b0;
        i_bready = 1'b0; d_bready = 1'b1; m_rdata = 64'h1111;
        #1;
        chk("to_grant", i_aready, 1);
        step();
        i_avalid = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            m_aready = (n == 0);
            if (n == 3) begin
                d_avalid = 1'b1;
                d_addr = 32'h80003000;
            end
            #1;
            if (i_bvalid) break;
            step();
            n++;
        end
        m_aready = 1'b0;
        chk("timeout_cycles", n, TO);
        chk("to_err", i_err, 1);
        chk("to_rdata", i_rdata, 0);
        chk("to_m_avalid", m_avalid, 0);
        chk("to_drain_bready", m_bready, 1);
        chk("to_d_side", {d_aready, d_bvalid, d_err}, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("to_err_held", {i_bvalid, i_err}, 2'b11);
        end
        i_bready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            i_bready = 1'b0;
            #1;
            chk("drain_no_grant", d_aready, 0);
            chk("drain_bready", m_bready, 1);
            chk("drain_busy", busy, 1);
            chk("drain_bvalid", {i_bvalid, d_bvalid}, 0);
        end
        m_bvalid = 1'b1;
        #1;
        chk("drain_discard", {i_bvalid, d_bvalid, d_aready}, 0);
        step();
        m_bvalid = 1'b0;
        model_last_d = 1'b0;
        $display("txn %0d: owner=I addr=80002000 timeout err", txn_no);
        txn_no++;
        run_one(1'b0, 1'b1, 32'h0, 32'h80003000, 64'h9, 8'h01, 64'hCC, 0, 1, 0, 1'b1);

        // Reset in the middle of RESP, then the first tie must go to I
        i_addr = 32'h80007000; i_avalid = 1'b1; d_avalid = 1'b1;
        i_bready = 1'b0; d_bready = 1'b0;
        #1;
        chk("mid_grant", i_aready, 1);
        step();
        m_aready = 1'b1;
        step();
        m_aready = 1'b0; m_bvalid = 1'b1; m_rdata = 64'h1234;
        #1;
        chk("mid_resp_bvalid", i_bvalid, 1);
        rst = 1'b0;
        #1;
        chk("arst_aready", {i_aready, d_aready}, 0);
        chk("arst_bvalid", {i_bvalid, d_bvalid, i_err, d_err}, 0);
        chk("arst_rdata", i_rdata, 0);
        chk("arst_m_ctrl", {m_avalid, m_bready, busy}, 0);
        chk("arst_m_addr", m_addr, 0);
        step();
        rst = 1'b1; m_bvalid = 1'b0;
        model_last_d = 1'b1;
        $display("txn %0d: owner=I addr=80007000 aborted by reset", txn_no);
        txn_no++;
        run_one(1'b1, 1'b1, 32'h80008000, 32'h80009000, 64'h5, 8'h3C, 64'hEE, 1, 1, 1, 1'b0);

        // Fixed priority: d keeps winning while it requests
        f_i_avalid = 1'b1; f_d_avalid = 1'b1;
        ci = 0; cd = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            ci += int'(f_i_aready);
            cd += int'(f_d_aready);
            step();
        end
        chk("fix_i_grants", ci, 0);
        chk("fix_d_grants", cd, 10);
        f_d_avalid = 1'b0;
        #1;
        chk("fix_i_after_d", f_i_aready, 1);
        step();
        f_i_avalid = 1'b0;
        $display("txn %0d: fixed-priority burst i=%0d d=%0d", txn_no, ci, cd);
        txn_no++;

        // Randomized traffic checked against the grant model
        for (int r = 0; r < 40; r++) begin
            int w;
            w = $urandom_range(1, 3);
            wi = w[0];
            wd = w[1];
            run_one(wi, wd, 32'h80000000 | ($urandom & 32'h0FFF_FFF8),
                    32'h90000000 | ($urandom & 32'h0FFF_FFF8),
                    {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    model_pick(wi, wd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one backing memory port between two requesters: the instruction-fetch cache refill port (i_*) and the data/LSU cache port (d_*).
- Uses the same avalid/aready/rdata/wdata/wstrb/bvalid/bready handshake as the cache interfaces.
- Allows one outstanding transaction, with round-robin or fixed data-first arbitration.
- A response timeout returns an error to the owning requester.
- Sits between the icache/dcache and the top-level memory model / AXI bridge.

Parameters:
- AW, 32: address width.
- DW, 64: data width; strobe width is DW/8.
- PRIO_D, 0: 0 selects round-robin; 1 selects fixed priority, where d always wins.
- TIMEOUT, 256: cycles allowed in REQ+RESP before error; minimum 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_addr  in  AW  fetch request address.
- i_avalid  in  1  fetch request valid.
- i_aready  out  1  one-cycle pulse: fetch request accepted.
- i_wdata  in  DW  fetch write data (tied 0 by the icache).
- i_wstrb  in  DW/8  fetch byte strobes; 0 means read.
- i_rdata  out  DW  fetch response data.
- i_bvalid  out  1  fetch response valid.
- i_bready  in  1  fetch response ready.
- i_err  out  1  qualifies i_bvalid: timeout error.
- d_addr, d_avalid, d_aready, d_wdata, d_wstrb, d_rdata, d_bvalid, d_bready, d_err: same widths and meanings as the i_* ports, for the data side.
- m_addr  out  AW  downstream address (latched).
- m_avalid  out  1  downstream request valid.
- m_aready  in  1  downstream request accepted.
- m_wdata  out  DW  downstream write data (latched).
- m_wstrb  out  DW/8  downstream strobes (latched).
- m_rdata  in  DW  downstream response data.
- m_bvalid  in  1  downstream response valid.
- m_bready  out  1  downstream response ready.
- busy  out  1  high in any state other than IDLE, or while draining.

Behaviour:
Reset (rst=0, asynchronous):
- State = IDLE; last_grant = D, so the first tie goes to I.
- owner, timer and drain are cleared.
- All outputs and latched m_addr/m_wdata/m_wstrb are 0.

IDLE (only when drain=0):
- Winner selection:
  - Only one avalid high: that requester wins.
  - Both high, PRIO_D=1: D wins.
  - Both high, PRIO_D=0: the requester that is not last_grant wins.
- Acceptance, same cycle: pulse the winner's aready for 1 cycle.
- Latch the winner's addr/wdata/wstrb; set owner and last_grant; timer=0.
- Next state = REQ.
- The loser sees no aready and keeps avalid high.

REQ:
- m_avalid=1 with latched fields, so m_avalid rises 1 cycle after the requester's aready.
- On m_aready: go to RESP.

RESP:
- m_bready = owner's bready.
- Owner's bvalid = m_bvalid; owner's rdata = m_rdata; err=0. The non-owner sees bvalid=0.
- On m_bvalid && m_bready: go to IDLE.
- A new grant is possible in the cycle after return, giving back-to-back throughput of one transaction per (mem latency + 2) cycles.

Timer:
- Counts every cycle in REQ and RESP.
- When timer reaches TIMEOUT-1 with no completion in that cycle, go to ERR.
- m_avalid drops in ERR; if the timeout hit in RESP, set drain=1.

ERR:
- Owner sees bvalid=1, err=1, rdata=0, held until the owner's bready; then IDLE.

Drain:
- While drain=1: m_bready=1, and no new grant is made (IDLE holds all aready low).
- Cleared on the first m_bvalid, which is discarded.

Other rules:
- Requester rdata is 0 whenever its bvalid=0.
- Requester aready never pulses outside IDLE.
- A requester deasserting avalid before its aready is harmless: it is not granted.
- Timeout and completion in the same cycle: completion wins.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs 0; downstream is expected to be reset by the same rst.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding IDLE=0, REQ=1, RESP=2, ERR=3;
  - owner encoding OWN_I=0, OWN_D=1;
  - AW/DW defaults.
- Natural sub-module rr_arb2: 2-input round-robin/fixed-priority picker, purely combinational on (req_i, req_d, last_grant, PRIO_D), returning grant_i/grant_d.
- FSM, latches, timer and response mux stay in mem_arbiter.

Test Plan:
1. Single fetch: i_avalid, i_addr=0x80000000, wstrb=0 → i_aready pulse in cycle 0, m_avalid in cycle 1 with m_addr=0x80000000. Memory returns 0x00000013_00000093 after 3 cycles → i_bvalid=1, i_rdata matches, i_err=0; d_bvalid stays 0.
2. Contention, PRIO_D=0: i and d held valid for 4 transactions → grants alternate I,D,I,D starting with I. PRIO_D=1 → D granted every time while d_avalid is high.
3. Data write: d_addr=0x80001000, d_wdata=0xDEADBEEF_CAFEF00D, d_wstrb=0x0F → m_* carry the same values; completion observed on d_bvalid only.
4. Backpressure: m_aready low for 5 cycles, then d_bready low for 3 cycles after m_bvalid → m_avalid held 5 cycles, m_bready=0 until d_bready, no second grant meanwhile.
5. Timeout with TIMEOUT=8, memory never answers → i_bvalid=1 with i_err=1, i_rdata=0. A late m_bvalid is drained with m_bready=1; a pending d request is granted only after the drain.
6. Reset asserted (rst=0) mid-RESP → all outputs 0 asynchronously; after release, the first tie is granted to I.
